// File: rtl/booth_mult_seq_pkg.sv
// Shared types and helpers for the iterative Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // One guard bit lets a single signed datapath also cover unsigned operands.
  function automatic int ext_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub into the upper half, then
// an arithmetic right shift of the whole product register.
module booth_step
  import mult_pkg::*;
#(
  parameter int E = 33
) (
  input  logic [2*E:0] prod,
  input  logic [E-1:0] m,
  input  logic [E-1:0] m_neg,
  output logic [2*E:0] prod_next
);

  logic [E-1:0] upper;

  always_comb begin
    upper = prod[2*E:E+1];
    case (prod[1:0])
      BOOTH_ADD: upper = upper + m;
      BOOTH_SUB: upper = upper + m_neg;
      default:   upper = prod[2*E:E+1];
    endcase
    prod_next = {upper[E-1], upper, prod[E:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, signed/unsigned, start/busy/done handshake.
// Optional BOOTH_MULT_EARLY_EXIT_EN: a zero operand skips the iterations.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int E      = ext_width(WIDTH);
  localparam int PW     = 2 * E + 1;
  localparam int PROD_W = 2 * WIDTH;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [PW-1:0]    prod, prod_next;
  logic [E-1:0]     m, m_neg, ext_a, ext_b;
  logic             last_step, zero_op;

  assign ext_a     = signed_mode ? {op_a[WIDTH-1], op_a} : {1'b0, op_a};
  assign ext_b     = signed_mode ? {op_b[WIDTH-1], op_b} : {1'b0, op_b};
  assign m_neg     = -m;
  assign last_step = (count == CNT_W'(1));

`ifdef BOOTH_MULT_EARLY_EXIT_EN
  assign zero_op = (op_a == '0) || (op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  booth_step #(.E(E)) u_step (
    .prod      (prod),
    .m         (m),
    .m_neg     (m_neg),
    .prod_next (prod_next)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = zero_op ? FIN : RUN;
      RUN:     if (last_step) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // hi/lo are loaded only on the final step (or early exit), so they never
  // expose partial sums and an aborted run leaves them at their reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      prod  <= '0;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m     <= ext_a;
          prod  <= {{E{1'b0}}, ext_b, 1'b0};
          count <= CNT_W'(E);
          if (zero_op) begin
            hi <= '0;
            lo <= '0;
          end
        end
        RUN: begin
          prod  <= prod_next;
          count <= count - CNT_W'(1);
          if (last_step) {hi, lo} <= PROD_W'(prod_next >> 1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mult_seq;

  typedef struct {
    logic        sm;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          due;
    int          busy_cyc;
    string       name;
  } exp_t;

  logic        clock, reset;
  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;

  int   cyc = 0, checks = 0, errors = 0, bc32 = 0, bc8 = 0;
  exp_t q32[$], q8[$];
  exp_t e32, e8;
  vec_t tab32[7], tab8[6];

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .signed_mode(sm32),
    .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumers: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (reset) bc32 = 0;
    else begin
      if (busy32) bc32++;
      if (done32) begin
        check("done_busy_excl32", 32'(busy32), 32'd0);
        if (q32.size() == 0) check("spurious_done32", 32'd1, 32'd0);
        else begin
          e32 = q32.pop_front();
          check({e32.name, "_hi"}, hi32, e32.hi);
          check({e32.name, "_lo"}, lo32, e32.lo);
          check({e32.name, "_latency"}, cyc, e32.due);
          check({e32.name, "_busy_cycles"}, bc32, e32.busy_cyc);
        end
        bc32 = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) bc8 = 0;
    else begin
      if (busy8) bc8++;
      if (done8) begin
        check("done_busy_excl8", 32'(busy8), 32'd0);
        if (q8.size() == 0) check("spurious_done8", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check({e8.name, "_hi"}, 32'(hi8), e8.hi);
          check({e8.name, "_lo"}, 32'(lo8), e8.lo);
          check({e8.name, "_latency"}, cyc, e8.due);
          check({e8.name, "_busy_cycles"}, bc8, e8.busy_cyc);
        end
        bc8 = 0;
      end
    end
  end

  task automatic launch(input bit narrow, input logic sm, input logic [31:0] a, b,
                        input logic [31:0] hi, lo, input string name);
    exp_t e;
    int   lat;
    @(negedge clock);
    lat = narrow ? 9 : 33;
`ifdef BOOTH_MULT_EARLY_EXIT_EN
    if (narrow ? (a[7:0] == 8'd0 || b[7:0] == 8'd0) : (a == 32'd0 || b == 32'd0)) lat = 0;
`endif
    e.hi = hi; e.lo = lo; e.due = cyc + 1 + lat; e.busy_cyc = lat; e.name = name;
    if (narrow) begin
      start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
      q8.push_back(e);
    end else begin
      start32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
      q32.push_back(e);
    end
    @(negedge clock);
    start8 = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      check("drain_timeout", 32'(q32.size() + q8.size()), 32'd0);
      q32.delete();
      q8.delete();
    end
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rs;
    int          pa, pb;
    logic [15:0] pr;

    tab32[0] = '{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tab32[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tab32[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tab32[3] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    tab32[4] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tab32[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tab32[6] = '{1'b0, 32'h12345678, 32'h00000002, 32'h00000000, 32'h2468ACF0};
    tab8[0]  = '{1'b1, 32'h80, 32'h80, 32'h40, 32'h00};
    tab8[1]  = '{1'b1, 32'h80, 32'hFF, 32'h00, 32'h80};
    tab8[2]  = '{1'b0, 32'hFF, 32'hFF, 32'hFE, 32'h01};
    tab8[3]  = '{1'b1, 32'h7F, 32'h80, 32'hC0, 32'h80};
    tab8[4]  = '{1'b0, 32'h7F, 32'h80, 32'h3F, 32'h80};
    tab8[5]  = '{1'b1, 32'h05, 32'hFD, 32'hFF, 32'hF1};

    reset = 1'b1;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
    repeat (3) @(negedge clock);
    check("rst_busy32", 32'(busy32), 32'd0);
    check("rst_done32", 32'(done32), 32'd0);
    check("rst_hi32", hi32, 32'd0);
    check("rst_lo32", lo32, 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_hi8", 32'(hi8), 32'd0);
    check("rst_lo8", 32'(lo8), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      launch(1'b0, tab32[i].sm, tab32[i].a, tab32[i].b, tab32[i].hi, tab32[i].lo,
             $sformatf("t32_%0d", i));
      drain();
    end
    for (int i = 0; i < 6; i++) begin
      launch(1'b1, tab8[i].sm, tab8[i].a, tab8[i].b, tab8[i].hi, tab8[i].lo,
             $sformatf("t8_%0d", i));
      drain();
    end

    // Random 8-bit vectors against a plain integer product.
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      pa = rs ? int'($signed(ra)) : int'(ra);
      pb = rs ? int'($signed(rb)) : int'(rb);
      pr = 16'(pa * pb);
      launch(1'b1, rs, 32'(ra), 32'(rb), 32'(pr[15:8]), 32'(pr[7:0]),
             $sformatf("rnd8_%0d", i));
      drain();
    end

    // A start during RUN must not queue or disturb the operation in flight.
    launch(1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "busy_start");
    repeat (5) @(negedge clock);
    start32 = 1'b1; sm32 = 1'b0; a32 = 32'd5; b32 = 32'd5;
    @(negedge clock);
    start32 = 1'b0;
    drain();
    repeat (4) @(negedge clock);
    check("busy_start_hold_hi", hi32, 32'hFFFFFFFF);
    check("busy_start_hold_lo", lo32, 32'hFFFFFFEB);

    // Reset in the middle of RUN aborts without a done pulse.
    launch(1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "abort");
    repeat (8) @(negedge clock);
    q32.delete();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy32), 32'd0);
    check("abort_done", 32'(done32), 32'd0);
    check("abort_hi", hi32, 32'd0);
    check("abort_lo", lo32, 32'd0);
    repeat (40) @(negedge clock);
    launch(1'b0, 1'b1, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFF9C, "after_abort");
    drain();

    // Zero operands: latency depends on the early-exit build option.
    launch(1'b0, 1'b0, 32'd0, 32'd1234, 32'd0, 32'd0, "zero32");
    drain();
    launch(1'b1, 1'b1, 32'h37, 32'h00, 32'd0, 32'd0, "zero8");
    drain();
    repeat (4) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised iterative radix-2 Booth multiplier and successor to the fixed 32-bit HI/LO multiplier in the MultDiv unit. It adds a configurable operand width and a signed/unsigned mode. It also adds an explicit start/busy/done handshake and a clean abort on reset. It feeds the HI/LO registers of the datapath, and the control unit launches it and waits for done.

Parameters:
WIDTH, 32, operand width in bits; must be at least 4.
CNT_W, $clog2(WIDTH+2), iteration counter width; derived, do not override.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only when busy=0
signed_mode  in  1  1: operands are two's complement; 0: operands are unsigned; sampled with start
op_a  in  WIDTH  multiplicand; sampled with start
op_b  in  WIDTH  multiplier; sampled with start
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when hi/lo carry a new result
hi  out  WIDTH  upper half of the 2*WIDTH product
lo  out  WIDTH  lower half of the 2*WIDTH product

Behaviour:
- Reset (synchronous, checked first every cycle): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal product register=0.
- Reset while in RUN aborts the operation. No done pulse is produced and no partial result reaches hi/lo.
- States and transitions:
  - IDLE: if start=1, load operands, go to RUN, busy=1 from the next cycle.
  - RUN: one Booth step per cycle while counter>0. When the step that brings counter to 0 completes, go to FIN.
  - FIN (one cycle): write hi/lo, done=1, busy=0, go to IDLE.
- In FIN, busy=0 but start is ignored. start is accepted only in IDLE, so the earliest relaunch is the cycle after done.
- start while busy=1 is ignored. It is not queued and does not disturb operands.
- Operands are extended to E=WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended if 0. This makes one datapath serve both modes.
- Product register P is 2E+1 bits, loaded as {E zeros, ext(op_b), 1'b0}. Add operands are M=ext(op_a) and its two's-complement negation.
- Each step:
  - inspect P[1:0]: 01 adds M to P[2E:E+1]; 10 adds -M to P[2E:E+1]; 00 and 11 make no change.
  - arithmetic right shift of the whole of P by 1, replicating bit 2E.
- counter loads E and performs E steps in total.
- Result = P[2E:1] truncated to the low 2*WIDTH bits. hi = bits [2W-1:W], lo = bits [W-1:0].
- Latency: start at cycle t gives done=1 at cycle t+E+1. hi/lo are valid from that cycle.
- hi/lo hold their values until the next done. They never show intermediate values.
- Boundary cases that must be exact:
  - signed: most-negative × most-negative gives +2^(2W-2); most-negative × -1 gives 2^(W-1) with hi=0.
  - unsigned: all-ones × all-ones gives 2^(2W) - 2^(W+1) + 1.
- done and busy are never high in the same cycle.

Optional Feature:
Macro BOOTH_MULT_EARLY_EXIT_EN.
- Defined: in IDLE, if start=1 and op_a==0 or op_b==0, skip RUN and go straight to FIN. done is pulsed at t+1 with hi=lo=0.
- Not defined: every operation takes the full t+E+1 latency, including zero operands.

Decomposition:
- Package mult_pkg holds:
  - state enum {IDLE, RUN, FIN};
  - Booth code constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10);
  - a function for the extended width E(WIDTH).
- One natural sub-module, booth_step: purely combinational; takes P, M and -M and returns the next P (add/sub plus arithmetic shift).
- Instantiate booth_step once. The parent module holds the FSM, counter and registers.

Test Plan:
- WIDTH=32, signed, op_a=7, op_b=-3, start at t → done at t+34; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high t+1..t+33.
- WIDTH=32, unsigned, op_a=op_b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001. Same operands signed → hi=0, lo=1.
- WIDTH=8, signed, op_a=op_b=8'h80 → hi=8'h40, lo=8'h00, done at t+10. Then op_a=8'h80, op_b=8'hFF → hi=8'h00, lo=8'h80.
- Assert start again with new operands during RUN → ignored; the first result is unchanged and only one done pulse occurs.
- Reset asserted mid-RUN (t+10) → next cycle busy=0, hi=lo=0, no done. A new start after reset gives the correct product.
- Zero operand, op_a=0, op_b=1234 → hi=lo=0. done at t+1 with BOOTH_MULT_EARLY_EXIT_EN defined; at t+E+1 without it.
